uart_mem_loader: RTL
====================

// Module: uart_mem_loader
// PURPOSE
// - UART program loader; feeds the i_mem byte-write port (mem_loader_write_*), directly upstream of instruction memory.
// - Receives framed binary images from a host, writes them byte-by-byte from BASE_ADDR, verifies a checksum.
// - Holds the CPU (cpu_hold) while a frame is in flight.
// PARAMETERS
// - CLK_FREQ_HZ   100_000_000  system clock frequency
// - BAUD_RATE     115_200      UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer div); elaboration $error if < 4
// - MEMORY_SIZE   8196         target memory size in bytes; upper bound on frame length
// - BASE_ADDR     0            byte address of the first payload byte
// - TIMEOUT_BITS  64           inter-byte timeout, in bit periods, while a frame is open
// PORTS
// - clk                    in   1   system clock
// - rst_n                  in   1   asynchronous active-low reset
// - uart_rx                in   1   serial input, idle high, 8N1, LSB first
// - mem_loader_write_addr  out  32  byte address to i_mem
// - mem_loader_write_data  out  8   byte data to i_mem
// - mem_loader_write_en    out  1   one-cycle write strobe
// - cpu_hold               out  1   high while a frame is being received
// - load_done              out  1   one-cycle pulse: frame complete, checksum good
// - load_error             out  1   sticky error flag; cleared by next accepted sync byte or reset
// BEHAVIOUR
// - Reset
//   - All outputs 0; FSM in IDLE; byte/checksum counters 0.
//   - rst_n low mid-frame aborts immediately, with no further writes.
// - Frame format
//   - SYNC 0xA5, LEN[31:0] little-endian (4 bytes), LEN payload bytes, CSUM.
//   - CSUM = 8-bit wrap-around sum of payload bytes.
// - FSM states
//   - IDLE: non-0xA5 bytes discarded. On 0xA5 -> LEN0; set cpu_hold, clear load_error.
//   - LEN0..LEN3: shift in length. After LEN3:
//     - LEN > MEMORY_SIZE -> ERROR.
//     - LEN == 0 -> CSUM.
//     - else -> DATA.
//   - DATA: each rx byte -> registered write next cycle (write_en=1 exactly 1 clk, write_addr = BASE_ADDR+idx); accumulate sum. idx==LEN-1 -> CSUM.
//   - CSUM: byte == sum -> DONE, else ERROR.
//   - DONE: load_done=1 for 1 clk, cpu_hold=0 -> IDLE.
//   - ERROR: load_error=1 (sticky), cpu_hold=0 -> IDLE. Bytes already written stay in memory.
// - Latency
//   - Byte valid from RX one cycle after stop-bit sample.
//   - Write strobe one cycle after byte valid.
// - Timeout
//   - In any state except IDLE/DONE/ERROR, TIMEOUT_BITS*CLKS_PER_BIT clks without a byte -> ERROR.
//   - Counter reloads on every received byte.
// - UART receive
//   - 2-FF synchronizer on uart_rx.
//   - Start detected on falling edge; recheck low at CLKS_PER_BIT/2, else treat as glitch and return to idle.
//   - Sample data bits at mid-bit.
//   - Stop bit must be 1: else drop the byte, no byte valid, raise framing flag. In a non-IDLE state the flag -> ERROR; in IDLE it is ignored.
//   - Back-to-back frames with no idle gap supported.
// - Widths
//   - idx is 32-bit; address add wraps modulo 2^32 (unreachable when LEN <= MEMORY_SIZE).
//   - Checksum is 8-bit modulo.
// STRUCTURE
// - Package loader_pkg:
//   - ldr_state_t enum {IDLE, LEN0, LEN1, LEN2, LEN3, DATA, CSUM, DONE, ERROR}
//   - SYNC_BYTE = 8'hA5
// - Sub-module uart_rx (CLKS_PER_BIT param): rx_byte[7:0], rx_valid pulse, rx_frame_err pulse.
// - Top: FSM, length/idx/checksum regs, timeout counter, registered write port.
// TESTING
// - Bench params: CLK 100 MHz, BAUD 10 Mbaud (CLKS_PER_BIT=10), MEMORY_SIZE=16, TIMEOUT_BITS=64.
// - Good frame A5 04 00 00 00 13 00 00 00 13
//   -> 4 writes addr 0..3 data 13,00,00,00; load_done pulse; load_error=0.
// - Bad checksum, same frame ending 14
//   -> 4 writes occur; no load_done; load_error=1; cpu_hold falls.
// - Oversize length A5 11 00 00 00
//   -> ERROR after LEN3; zero writes; load_error=1.
// - Noise 00 FF 5A then good frame
//   -> noise ignored, cpu_hold stays 0 until A5; frame loads correctly.
// - Stall after 2 payload bytes for 640+ clks
//   -> ERROR, 2 writes only.
// - Framing and reset
//   - Payload byte with stop bit 0 -> ERROR.
//   - rst_n pulse mid-DATA -> all outputs 0, no further writes.

Source files
------------

// File: rtl/uart_mem_loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  // Loader frame-parsing states.
  typedef enum logic [3:0] {
    IDLE,
    LEN0,
    LEN1,
    LEN2,
    LEN3,
    DATA,
    CSUM,
    DONE,
    ERROR
  } ldr_state_t;

  // UART receiver bit-level states.
  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_mem_loader_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, registered
// byte/valid/framing-error outputs (valid one cycle after the stop sample).
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);
  import loader_pkg::*;

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d, byte_q, byte_d;
  logic             valid_q, valid_d, ferr_q, ferr_d;

  // Next-state logic: edge detect, half-bit start recheck, mid-bit sampling.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_END) begin
          // A start bit that is no longer low at mid-bit is a glitch.
          state_d = sync2_q ? R_IDLE : R_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // State registers; synchronizer and edge history reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte      = byte_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_mem_loader.sv
// UART program loader: parses SYNC/LEN/payload/CSUM frames, writes payload
// bytes to instruction memory from BASE_ADDR and holds the CPU meanwhile.
module uart_mem_loader #(
  parameter int          CLK_FREQ_HZ  = 100_000_000,
  parameter int          BAUD_RATE    = 115_200,
  parameter int          MEMORY_SIZE  = 8196,
  parameter logic [31:0] BASE_ADDR    = 32'd0,
  parameter int          TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [31:0] mem_loader_write_addr,
  output logic [7:0]  mem_loader_write_data,
  output logic        mem_loader_write_en,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);
  import loader_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W        = $clog2(TMO_LIMIT + 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_mem_loader: CLKS_PER_BIT must be at least 4");
  end

  logic [7:0] rx_byte;
  logic       rx_valid, rx_frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (uart_rx),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  ldr_state_t       state_q, state_d;
  logic [31:0]      len_q, len_d, idx_q, idx_d, len_new;
  logic [7:0]       sum_q, sum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wen_q, wen_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic             active;

  // Frame parser, timeout and registered write-port/status next-state logic.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
    len_new = {rx_byte, len_q[31:8]};
    active  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
    tmo_d   = (rx_valid || !active) ? '0 : tmo_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = LEN0;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          len_d   = '0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      LEN0, LEN1, LEN2: begin
        if (rx_valid) begin
          len_d   = len_new;
          state_d = ldr_state_t'(state_q + 4'd1);
        end
      end
      LEN3: begin
        if (rx_valid) begin
          len_d = len_new;
          if (len_new > 32'(MEMORY_SIZE)) state_d = ERROR;
          else if (len_new == 32'd0)      state_d = CSUM;
          else                            state_d = DATA;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wen_d   = 1'b1;
          waddr_d = BASE_ADDR + idx_q;
          wdata_d = rx_byte;
          sum_d   = sum_q + rx_byte;
          idx_d   = idx_q + 32'd1;
          if (idx_q == len_q - 32'd1) state_d = CSUM;
        end
      end
      CSUM: begin
        if (rx_valid) state_d = (rx_byte == sum_q) ? DONE : ERROR;
      end
      DONE, ERROR: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    // Line errors and inter-byte silence abort any open frame.
    if (active && (rx_frame_err || (!rx_valid && tmo_q == TMO_W'(TMO_LIMIT - 1))))
      state_d = ERROR;
    if (state_d == DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
    if (state_d == ERROR && state_q != ERROR) begin
      err_d  = 1'b1;
      hold_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame with outputs low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_loader_write_addr = waddr_q;
  assign mem_loader_write_data = wdata_q;
  assign mem_loader_write_en   = wen_q;
  assign cpu_hold              = hold_q;
  assign load_done             = done_q;
  assign load_error            = err_q;

endmodule
